vmem_port_arbiter: RTL and testbench

Shares the single L1 data-cache port between the scalar core's load/store path (requester 0) and the vector memory unit (requester 1).
- Arbitrates requests round-robin.
- Tracks outstanding responses in a small ID FIFO.
- Steers each cache response back to the requester that issued it.
- Sits between the vector top-level cache request/response interface, the scalar LSU and the cache.

---
 rtl/vmem_arb_pkg.sv | 23 ++
 rtl/vmem_id_fifo.sv | 69 ++++++
 rtl/vmem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_vmem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_arb_pkg.sv
// Shared types and constants for the vector-memory / scalar-LSU cache port arbiter.
package vmem_arb_pkg;

  localparam int REQ_W_DEF     = 256 + 64;
  localparam int RESP_W_DEF    = 256 + 8;
  localparam int MAX_OUTST_DEF = 4;
  localparam int OUTST_W       = $clog2(MAX_OUTST_DEF) + 1;

  typedef enum logic {
    REQ_SCALAR = 1'b0,
    REQ_VECTOR = 1'b1
  } req_id_e;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  function automatic req_id_e other_id(input req_id_e id);
    return (id == REQ_SCALAR) ? REQ_VECTOR : REQ_SCALAR;
  endfunction

endpackage

// File: rtl/vmem_id_fifo.sv
// Small FIFO of requester IDs for responses still owed by the cache.
// It exposes its occupancy so the arbiter can report how many responses are in flight.
module vmem_id_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_wdata,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // A push at full is only accepted alongside a pop, which frees the slot being written.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/vmem_port_arbiter.sv
// Round-robin arbiter sharing the L1 data-cache port between the scalar LSU (0) and the
// vector memory unit (1); responses are steered back in request order via an ID FIFO.
module vmem_port_arbiter
  import vmem_arb_pkg::*;
#(
  parameter int REQ_W     = REQ_W_DEF,
  parameter int RESP_W    = RESP_W_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req0_valid_i,
  input  logic [REQ_W-1:0]              req0_data_i,
  input  logic                          req0_resp_exp_i,
  output logic                          req0_ready_o,
  input  logic                          req1_valid_i,
  input  logic [REQ_W-1:0]              req1_data_i,
  input  logic                          req1_resp_exp_i,
  output logic                          req1_ready_o,
  output logic                          mem_req_valid_o,
  output logic [REQ_W-1:0]              mem_req_o,
  input  logic                          cache_ready_i,
  input  logic                          mem_resp_valid_i,
  input  logic [RESP_W-1:0]             mem_resp_i,
  output logic                          resp0_valid_o,
  output logic                          resp1_valid_o,
  output logic [RESP_W-1:0]             resp_o,
  output logic [$clog2(MAX_OUTST):0]    outstanding_o,
  output logic                          idle_o,
  output logic                          err_o
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  lock_state_e       r_lock_state;
  lock_state_e       w_lock_state_nxt;
  req_id_e           r_lock_id;
  req_id_e           w_lock_id_nxt;
  req_id_e           r_rr_last;
  req_id_e           w_grant;
  logic              w_gnt_valid;
  logic              w_gnt_exp;
  logic              w_can_issue;
  logic              w_hs;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [0:0]        w_fifo_wdata;
  logic [0:0]        w_head;
  logic [CNT_W-1:0]  w_count;
  logic              r_resp0_valid;
  logic              r_resp1_valid;
  logic [RESP_W-1:0] r_resp_data;
  logic              r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_state <= LOCK_IDLE;
      r_lock_id    <= REQ_SCALAR;
    end else begin
      r_lock_state <= w_lock_state_nxt;
      r_lock_id    <= w_lock_id_nxt;
    end
  end

  // The lock keeps the cache-port payload stable until the stalled request is taken;
  // a requester that withdraws while locked simply releases the lock.
  always_comb begin
    w_lock_state_nxt = r_lock_state;
    w_lock_id_nxt    = r_lock_id;
    case (r_lock_state)
      LOCK_IDLE: begin
        if (mem_req_valid_o && !cache_ready_i) begin
          w_lock_state_nxt = LOCK_HELD;
          w_lock_id_nxt    = w_grant;
        end
      end
      LOCK_HELD: begin
        if (w_hs || !w_gnt_valid) w_lock_state_nxt = LOCK_IDLE;
      end
      default: w_lock_state_nxt = LOCK_IDLE;
    endcase
  end

  always_comb begin
    w_grant = REQ_SCALAR;
    if (r_lock_state == LOCK_HELD) begin
      w_grant = r_lock_id;
    end else if (req0_valid_i && req1_valid_i) begin
      w_grant = other_id(r_rr_last);
    end else if (req1_valid_i) begin
      w_grant = REQ_VECTOR;
    end
  end

  always_comb begin
    w_gnt_valid = req0_valid_i;
    w_gnt_exp   = req0_resp_exp_i;
    mem_req_o   = req0_data_i;
    if (w_grant == REQ_VECTOR) begin
      w_gnt_valid = req1_valid_i;
      w_gnt_exp   = req1_resp_exp_i;
      mem_req_o   = req1_data_i;
    end
  end

  // Stores never occupy a FIFO slot, so they may still issue while the FIFO is full.
  assign w_can_issue     = ~(w_gnt_exp & w_fifo_full);
  assign mem_req_valid_o = w_gnt_valid & w_can_issue;
  assign req0_ready_o    = (w_grant == REQ_SCALAR) & w_can_issue & cache_ready_i;
  assign req1_ready_o    = (w_grant == REQ_VECTOR) & w_can_issue & cache_ready_i;
  assign w_hs            = mem_req_valid_o & cache_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last <= REQ_VECTOR;
    end else if (w_hs) begin
      r_rr_last <= w_grant;
    end
  end

  assign w_push       = w_hs & w_gnt_exp;
  assign w_pop        = mem_resp_valid_i & ~w_fifo_empty;
  assign w_fifo_wdata = w_grant;

  vmem_id_fifo #(
    .DEPTH (MAX_OUTST),
    .DW    (1)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  // The pop reads the head as it stood before this cycle's push, so a response is
  // never routed to the request issued in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_resp_data   <= '0;
    end else if (w_pop) begin
      r_resp0_valid <= (w_head == REQ_SCALAR);
      r_resp1_valid <= (w_head == REQ_VECTOR);
      r_resp_data   <= mem_resp_i;
    end else begin
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (mem_resp_valid_i && w_fifo_empty) begin
      r_err <= 1'b1;
    end
  end

  assign resp0_valid_o = r_resp0_valid;
  assign resp1_valid_o = r_resp1_valid;
  assign resp_o        = r_resp_data;
  assign err_o         = r_err;
  assign outstanding_o = w_count;
  assign idle_o        = ~req0_valid_i & ~req1_valid_i & (w_count == '0) &
                         ~r_resp0_valid & ~r_resp1_valid;

endmodule

// File: tb/tb_vmem_port_arbiter.sv
// Self-checking bench: a directed vector table for the multi-cycle corner cases, a
// reset-mid-operation sequence, then random traffic against a queue-based model.
module tb_vmem_port_arbiter;

  localparam int REQ_W     = 320;
  localparam int RESP_W    = 264;
  localparam int MAX_OUTST = 4;
  localparam int CW        = $clog2(MAX_OUTST) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid_i, req0_resp_exp_i, req0_ready_o;
  logic              req1_valid_i, req1_resp_exp_i, req1_ready_o;
  logic [REQ_W-1:0]  req0_data_i, req1_data_i, mem_req_o;
  logic              mem_req_valid_o, cache_ready_i, mem_resp_valid_i;
  logic [RESP_W-1:0] mem_resp_i, resp_o;
  logic              resp0_valid_o, resp1_valid_o, idle_o, err_o;
  logic [CW-1:0]     outstanding_o;

  int checks = 0;
  int errors = 0;

  vmem_port_arbiter #(
    .REQ_W     (REQ_W),
    .RESP_W    (RESP_W),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req0_valid_i     (req0_valid_i),
    .req0_data_i      (req0_data_i),
    .req0_resp_exp_i  (req0_resp_exp_i),
    .req0_ready_o     (req0_ready_o),
    .req1_valid_i     (req1_valid_i),
    .req1_data_i      (req1_data_i),
    .req1_resp_exp_i  (req1_resp_exp_i),
    .req1_ready_o     (req1_ready_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_o        (mem_req_o),
    .cache_ready_i    (cache_ready_i),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_i       (mem_resp_i),
    .resp0_valid_o    (resp0_valid_o),
    .resp1_valid_o    (resp1_valid_o),
    .resp_o           (resp_o),
    .outstanding_o    (outstanding_o),
    .idle_o           (idle_o),
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired before the test completed");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    bit v0, e0, v1, e1, cr, rv;
    bit xRdy0, xRdy1, xMv, xGnt, xIdle;
    int xOut;
    bit xR0, xR1, xErr;
  } vec_t;

  vec_t tbl[$];

  task automatic checkOutput(input string name, input logic [REQ_W-1:0] act,
                             input logic [REQ_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit v0, input bit e0, input bit v1, input bit e1,
                               input bit cr, input bit rv, input logic [REQ_W-1:0] d0,
                               input logic [REQ_W-1:0] d1, input logic [RESP_W-1:0] rd);
    req0_valid_i     = v0;
    req0_resp_exp_i  = e0;
    req1_valid_i     = v1;
    req1_resp_exp_i  = e1;
    cache_ready_i    = cr;
    mem_resp_valid_i = rv;
    req0_data_i      = d0;
    req1_data_i      = d1;
    mem_resp_i       = rd;
  endtask

  function automatic logic [REQ_W-1:0] randReq();
    logic [REQ_W-1:0] r;
    for (int i = 0; i < REQ_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [RESP_W-1:0] randResp();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
    return t[RESP_W-1:0];
  endfunction

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, '0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  // Reference state: ID queue in issue order plus arbitration memory.
  int mQ[$];
  bit mLock;
  int mLockId;
  int mRr;
  bit mR0, mR1, mErr;
  logic [RESP_W-1:0] mResp;

  initial begin
    logic [REQ_W-1:0]  d0, d1;
    logic [RESP_W-1:0] rd;
    vec_t v;

    // Reset values
    doReset();
    checkOutput("rst.outst", REQ_W'(outstanding_o), 0);
    checkOutput("rst.resp0", REQ_W'(resp0_valid_o), 0);
    checkOutput("rst.resp1", REQ_W'(resp1_valid_o), 0);
    checkOutput("rst.resp_o", REQ_W'(resp_o), 0);
    checkOutput("rst.err", REQ_W'(err_o), 0);
    checkOutput("rst.idle", REQ_W'(idle_o), 1);

    //                 v0 e0 v1 e1 cr rv  rdy0 rdy1 mv gnt idle out r0 r1 err
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0});
    tbl.push_back(vec_t'{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 2, 0, 0, 0});
    tbl.push_back(vec_t'{1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 0, 3, 0, 0, 0});
    tbl.push_back(vec_t'{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 4, 0, 0, 0});
    tbl.push_back(vec_t'{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0});
    tbl.push_back(vec_t'{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 4, 0, 0, 0});
    tbl.push_back(vec_t'{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 0, 3, 1, 0, 0});
    tbl.push_back(vec_t'{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 0, 3, 0, 1, 0});
    tbl.push_back(vec_t'{1, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 2, 1, 0, 0});
    tbl.push_back(vec_t'{1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0});
    tbl.push_back(vec_t'{1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0});
    tbl.push_back(vec_t'{1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 0, 3, 0, 0, 0});
    tbl.push_back(vec_t'{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 4, 0, 0, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 3, 0, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 2, 0, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1});

    d0 = randReq();
    d1 = randReq();
    foreach (tbl[i]) begin
      v  = tbl[i];
      rd = randResp();
      applyStimulus(v.v0, v.e0, v.v1, v.e1, v.cr, v.rv, d0, d1, rd);
      #3;
      checkOutput($sformatf("t%0d.rdy0", i), REQ_W'(req0_ready_o), REQ_W'(v.xRdy0));
      checkOutput($sformatf("t%0d.rdy1", i), REQ_W'(req1_ready_o), REQ_W'(v.xRdy1));
      checkOutput($sformatf("t%0d.mvalid", i), REQ_W'(mem_req_valid_o), REQ_W'(v.xMv));
      checkOutput($sformatf("t%0d.idle", i), REQ_W'(idle_o), REQ_W'(v.xIdle));
      if (v.xMv) checkOutput($sformatf("t%0d.mreq", i), mem_req_o, v.xGnt ? d1 : d0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("t%0d.outst", i), REQ_W'(outstanding_o), REQ_W'(v.xOut));
      checkOutput($sformatf("t%0d.resp0", i), REQ_W'(resp0_valid_o), REQ_W'(v.xR0));
      checkOutput($sformatf("t%0d.resp1", i), REQ_W'(resp1_valid_o), REQ_W'(v.xR1));
      checkOutput($sformatf("t%0d.err", i), REQ_W'(err_o), REQ_W'(v.xErr));
      if (v.xR0 || v.xR1) checkOutput($sformatf("t%0d.resp_o", i), REQ_W'(resp_o), REQ_W'(rd));
    end

    // Reset with two loads outstanding and err already set
    applyStimulus(1, 1, 0, 0, 1, 0, d0, d1, '0);
    @(posedge clk); #1;
    applyStimulus(0, 0, 1, 1, 1, 0, d0, d1, '0);
    @(posedge clk); #1;
    checkOutput("rmid.outst_before", REQ_W'(outstanding_o), 2);
    applyStimulus(0, 0, 0, 0, 0, 0, d0, d1, '0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rmid.outst", REQ_W'(outstanding_o), 0);
    checkOutput("rmid.err", REQ_W'(err_o), 0);
    checkOutput("rmid.idle", REQ_W'(idle_o), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rd = randResp();
    applyStimulus(0, 0, 0, 0, 1, 1, d0, d1, rd);
    @(posedge clk); #1;
    checkOutput("rlate.err", REQ_W'(err_o), 1);
    checkOutput("rlate.resp0", REQ_W'(resp0_valid_o), 0);
    checkOutput("rlate.resp1", REQ_W'(resp1_valid_o), 0);

    // Random traffic against the reference model
    doReset();
    mQ.delete();
    mLock = 0; mLockId = 0; mRr = 1;
    mR0 = 0; mR1 = 0; mErr = 0; mResp = '0;
    for (int n = 0; n < 600; n++) begin
      bit v0, e0, v1, e1, cr, rv, gv, ge, can, mv, hs;
      int g;
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      e0 = $urandom_range(0, 1);
      e1 = $urandom_range(0, 1);
      cr = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 2) == 0);
      d0 = randReq();
      d1 = randReq();
      rd = randResp();
      applyStimulus(v0, e0, v1, e1, cr, rv, d0, d1, rd);

      if (mLock) g = mLockId;
      else if (v0 && v1) g = (mRr == 0) ? 1 : 0;
      else if (v1) g = 1;
      else g = 0;
      gv  = (g == 1) ? v1 : v0;
      ge  = (g == 1) ? e1 : e0;
      can = !(ge && mQ.size() == MAX_OUTST);
      mv  = gv && can;
      hs  = mv && cr;

      #3;
      checkOutput($sformatf("r%0d.mvalid", n), REQ_W'(mem_req_valid_o), REQ_W'(mv));
      checkOutput($sformatf("r%0d.rdy0", n), REQ_W'(req0_ready_o), REQ_W'(g == 0 && can && cr));
      checkOutput($sformatf("r%0d.rdy1", n), REQ_W'(req1_ready_o), REQ_W'(g == 1 && can && cr));
      checkOutput($sformatf("r%0d.idle", n), REQ_W'(idle_o),
                  REQ_W'(!v0 && !v1 && mQ.size() == 0 && !mR0 && !mR1));
      if (mv) checkOutput($sformatf("r%0d.mreq", n), mem_req_o, (g == 1) ? d1 : d0);
      @(posedge clk);

      mR0 = 0;
      mR1 = 0;
      if (rv) begin
        if (mQ.size() > 0) begin
          int id;
          id = mQ.pop_front();
          mR0 = (id == 0);
          mR1 = (id == 1);
          mResp = rd;
        end else begin
          mErr = 1;
        end
      end
      if (hs && ge) mQ.push_back(g);
      if (hs) begin
        mLock = 0;
        mRr = g;
      end else if (mv && !cr) begin
        mLock = 1;
        mLockId = g;
      end else if (mLock && !gv) begin
        mLock = 0;
      end

      #1;
      checkOutput($sformatf("r%0d.outst", n), REQ_W'(outstanding_o), REQ_W'(mQ.size()));
      checkOutput($sformatf("r%0d.resp0", n), REQ_W'(resp0_valid_o), REQ_W'(mR0));
      checkOutput($sformatf("r%0d.resp1", n), REQ_W'(resp1_valid_o), REQ_W'(mR1));
      checkOutput($sformatf("r%0d.err", n), REQ_W'(err_o), REQ_W'(mErr));
      checkOutput($sformatf("r%0d.resp_o", n), REQ_W'(resp_o), REQ_W'(mResp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
